// File: rtl/uart_mmio_resp.sv
// uart_mmio_resp: memory-mapped console UART responder on the CPU data-sram bus.
// A small TX FIFO is drained one byte at a time with a fixed idle gap between bytes.
// The console input is polled periodically, and one received character is held until it is read.
module uart_mmio_resp #(
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          TX_GAP     = 4,
    parameter int          RX_POLL    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [7:0]  we,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        io_uart_out_valid,
    output logic [7:0]  io_uart_out_ch,
    output logic        io_uart_in_valid,
    input  logic [7:0]  io_uart_in_ch
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [7:0] GAP_LAST  = 8'((TX_GAP > 0) ? (TX_GAP - 1) : 0);
    localparam logic [7:0] POLL_LAST = 8'((RX_POLL > 0) ? (RX_POLL - 1) : 0);
    localparam logic [7:0] OFF_TX     = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_RX     = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } tx_state_t;

    tx_state_t       state_q, state_d;
    logic [7:0]      gap_q, gap_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_ch_q, out_ch_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            rx_valid_q, rx_valid_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic [7:0]      poll_cnt_q, poll_cnt_d;
    logic [63:0]     rdata_q, rdata_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    // Bus decode: a window hit is a write if any byte enable is set, otherwise a read.
    logic        sel;
    logic [7:0]  off;
    logic        rd_sel;
    logic        wr_sel;
    assign sel    = en && (addr[63:8] == BASE_ADDR[63:8]);
    assign off    = addr[7:0];
    assign rd_sel = sel && (we == 8'h00);
    assign wr_sel = sel && (we != 8'h00);

    // Only the low data byte and the clear bit of wdata carry meaning here.
    logic unused_wdata;
    assign unused_wdata = ^wdata[63:8];

    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    head;
    logic [7:0]    head_next;
    logic [PW-1:0] rd_ptr_inc;
    logic          ovf_clr;
    logic          poll;
    logic          rx_clr;
    logic [63:0]   status;

    assign pop        = (state_q == ST_SEND);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push_req   = wr_sel && (off == OFF_TX) && we[0];
    assign push_ok    = push_req && (!fifo_full || pop);
    assign rd_ptr_inc = rd_ptr_q + PW'(1);
    assign head       = mem_q[rd_ptr_q];
    assign head_next  = mem_q[rd_ptr_inc];
    assign ovf_clr    = wr_sel && (off == OFF_STATUS) && we[0] && wdata[3];
    assign poll       = !rx_valid_q && (poll_cnt_q == POLL_LAST);
    assign rx_clr     = rd_sel && (off == OFF_RX) && rx_valid_q;
    assign status     = {48'h0, 8'(count_q), 4'h0, ovf_q, rx_valid_q, fifo_empty, fifo_full};

    assign rdata             = rdata_q;
    assign io_uart_out_valid = out_valid_q;
    assign io_uart_out_ch    = out_ch_q;
    assign io_uart_in_valid  = poll;

    // FIFO pointer/count bookkeeping; a pop frees the slot a same-cycle push needs.
    always_comb begin
        wr_ptr_d = push_ok ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_inc : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
        ovf_d = ovf_q;
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // TX sequencer: the strobe is launched on entry to SEND, and the head pops during SEND.
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        out_valid_d = 1'b0;
        out_ch_d    = out_ch_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d     = ST_SEND;
                    out_valid_d = 1'b1;
                    out_ch_d    = head;
                end
            end
            ST_SEND: begin
                if (TX_GAP != 0) begin
                    state_d = ST_GAP;
                    gap_d   = 8'h00;
                end else if (count_q > CW'(1)) begin
                    state_d     = ST_SEND;
                    out_valid_d = 1'b1;
                    out_ch_d    = head_next;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = 8'h00;
                    if (!fifo_empty) begin
                        state_d     = ST_SEND;
                        out_valid_d = 1'b1;
                        out_ch_d    = head;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 8'h01;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RX poller: counts only while no character is held; a read of RXDATA releases the holder.
    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        poll_cnt_d = poll_cnt_q;
        if (rx_clr) begin
            rx_valid_d = 1'b0;
        end else if (!rx_valid_q) begin
            if (poll) begin
                poll_cnt_d = 8'h00;
                if (io_uart_in_ch != 8'hFF) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = io_uart_in_ch;
                end
            end else begin
                poll_cnt_d = poll_cnt_q + 8'h01;
            end
        end
    end

    // Read data mux: only a window read updates rdata, everything else holds it.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_sel) begin
            case (off)
                OFF_STATUS: rdata_d = status;
                OFF_RX:     rdata_d = rx_valid_q ? {56'h0, rx_data_q} : 64'hFF;
                default:    rdata_d = 64'h0;
            endcase
        end
    end

    // FIFO storage has no reset; pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata[7:0];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gap_q       <= 8'h00;
            out_valid_q <= 1'b0;
            out_ch_q    <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            poll_cnt_q  <= 8'h00;
            rdata_q     <= 64'h0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            poll_cnt_q  <= poll_cnt_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_uart_mmio_resp.sv
// Testbench for uart_mmio_resp: directed scenarios followed by a randomized run
// checked against a queue-based behavioural model of the console UART.
module tb_uart_mmio_resp;

    localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;
    localparam logic [63:0] A_TX = BASE + 64'h00;
    localparam logic [63:0] A_ST = BASE + 64'h08;
    localparam logic [63:0] A_RX = BASE + 64'h10;
    localparam int DEPTH = 8;
    localparam int GAP   = 4;
    localparam int POLL  = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  we = 8'h00;
    logic [63:0] addr = 64'h0;
    logic [63:0] wdata = 64'h0;
    logic [7:0]  in_ch = 8'hFF;
    logic [63:0] rdata;
    logic        out_valid;
    logic [7:0]  out_ch;
    logic        in_valid;

    int tests = 0;
    int fails = 0;
    int sent_cnt = 0;

    uart_mmio_resp dut (
        .clock             (clock),
        .reset             (reset),
        .en                (en),
        .we                (we),
        .addr              (addr),
        .wdata             (wdata),
        .rdata             (rdata),
        .io_uart_out_valid (out_valid),
        .io_uart_out_ch    (out_ch),
        .io_uart_in_valid  (in_valid),
        .io_uart_in_ch     (in_ch)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock step; outputs are sampled 1ns after the edge, strobes are tallied.
    task automatic tick();
        @(posedge clock);
        #1;
        if (out_valid === 1'b1) sent_cnt++;
    endtask

    task automatic bus(input logic e, input logic [7:0] w, input logic [63:0] a, input logic [63:0] d);
        en = e; we = w; addr = a; wdata = d;
    endtask

    task automatic bus_idle();
        bus(1'b0, 8'h00, 64'h0, 64'h0);
    endtask

    task automatic drain(input int n);
        bus_idle();
        repeat (n) tick();
    endtask

    // Writes one byte into an idle FIFO, then a back-to-back burst starting in its gap.
    task automatic first_then_burst(input int n_burst);
        bus(1'b1, 8'h01, A_TX, 64'hA0);
        tick();
        bus_idle();
        tick();
        tick();
        for (int i = 0; i < n_burst; i++) begin
            bus(1'b1, 8'h01, A_TX, 64'(i + 1));
            tick();
        end
        bus_idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_idle();
        repeat (3) tick();
        tests++; if (rdata !== 64'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (out_ch !== 8'h00) begin fails++; $display("FAIL reset_out_ch: got %h want 00", out_ch); end
        tests++; if (in_valid !== 1'b0) begin fails++; $display("FAIL reset_in_valid: got %b want 0", in_valid); end
        reset = 1'b0;
        bus(1'b1, 8'h00, A_ST, 64'h0);
        tick();
        bus_idle();
        tests++; if (rdata !== 64'h2) begin fails++; $display("FAIL reset_status: got %h want 2", rdata); end
        $display("[TB] reset: outputs zero, STATUS=%h", rdata);
        drain(20);
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        bus(1'b1, 8'h01, A_TX, 64'h41);
        tick();
        for (int c = 1; c < 15; c++) begin
            if (c == 1) bus(1'b1, 8'h01, A_TX, 64'h42);
            else bus_idle();
            exp_v = (c == 2) || (c == 2 + 1 + GAP);
            tests++;
            if (out_valid !== exp_v) begin
                fails++; $display("FAIL b2b_valid cycle+%0d: got %b want %b", c, out_valid, exp_v);
            end
            if (c >= 2) begin
                tests++;
                if (out_ch !== ((c >= 2 + 1 + GAP) ? 8'h42 : 8'h41)) begin
                    fails++; $display("FAIL b2b_ch cycle+%0d: got %h want %h", c, out_ch,
                                      (c >= 2 + 1 + GAP) ? 8'h42 : 8'h41);
                end
            end
            if (exp_v) $display("[TB] back_to_back: ch=%h at cycle +%0d", out_ch, c);
            tick();
        end
        drain(20);
    endtask

    task automatic test_full_send_push();
        sent_cnt = 0;
        first_then_burst(10);
        bus(1'b1, 8'h00, A_ST, 64'h0);
        tick();
        bus_idle();
        tests++; if (rdata !== 64'h0801) begin fails++; $display("FAIL full_send_push_status: got %h want 0801", rdata); end
        $display("[TB] full_send_push: STATUS=%h", rdata);
        drain(100);
        tests++; if (sent_cnt != 11) begin fails++; $display("FAIL full_send_push_bytes: got %0d want 11", sent_cnt); end
    endtask

    task automatic test_overflow();
        sent_cnt = 0;
        first_then_burst(12);
        bus(1'b1, 8'h00, A_ST, 64'h0);
        tick();
        tests++; if (rdata !== 64'h0809) begin fails++; $display("FAIL overflow_status: got %h want 0809", rdata); end
        $display("[TB] overflow: STATUS=%h", rdata);
        bus(1'b1, 8'h01, A_ST, 64'h8);
        tick();
        tests++; if (rdata !== 64'h0809) begin fails++; $display("FAIL overflow_rdata_hold: got %h want 0809", rdata); end
        bus(1'b1, 8'h00, A_ST, 64'h0);
        tick();
        bus_idle();
        tests++; if (rdata !== 64'h0801) begin fails++; $display("FAIL overflow_clear: got %h want 0801", rdata); end
        $display("[TB] overflow clear: STATUS=%h", rdata);
        drain(100);
        tests++; if (sent_cnt != 11) begin fails++; $display("FAIL overflow_bytes: got %0d want 11", sent_cnt); end
    endtask

    task automatic test_rx();
        int polls = 0;
        int first = -1;
        bus_idle();
        for (int i = 0; i < 200 && polls < 4; i++) begin
            if (in_valid === 1'b1) begin
                polls++;
                in_ch = (polls == 4) ? 8'h5A : 8'hFF;
            end else begin
                in_ch = 8'hFF;
            end
            tick();
        end
        in_ch = 8'hFF;
        tests++; if (polls != 4) begin fails++; $display("FAIL rx_polls: got %0d want 4", polls); end
        bus(1'b1, 8'h00, A_ST, 64'h0);
        tick();
        tests++; if (rdata !== 64'h6) begin fails++; $display("FAIL rx_status: got %h want 6", rdata); end
        tests++; if (in_valid !== 1'b0) begin fails++; $display("FAIL rx_no_poll_held: got %b want 0", in_valid); end
        bus(1'b1, 8'h00, A_RX, 64'h0);
        tick();
        tests++; if (rdata !== 64'h5A) begin fails++; $display("FAIL rx_data: got %h want 5a", rdata); end
        $display("[TB] rx: RXDATA=%h", rdata);
        bus(1'b1, 8'h00, A_RX, 64'h0);
        tick();
        bus_idle();
        tests++; if (rdata !== 64'hFF) begin fails++; $display("FAIL rx_empty: got %h want ff", rdata); end
        for (int k = 2; k < 40; k++) begin
            if (in_valid === 1'b1) begin
                first = k;
                break;
            end
            tick();
        end
        tests++; if (first != POLL) begin fails++; $display("FAIL rx_poll_resume: got %0d want %0d", first, POLL); end
        $display("[TB] rx: poll resumed %0d cycles after clearing read", first);
        drain(5);
    endtask

    task automatic test_reset_mid();
        int snap;
        for (int i = 0; i < 5; i++) begin
            bus(1'b1, 8'h01, A_TX, 64'(8'h60 + i));
            tick();
        end
        bus_idle();
        reset = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
        tick();
        tests++; if (rdata !== 64'h0) begin fails++; $display("FAIL mid_reset_rdata: got %h want 0", rdata); end
        tests++; if (out_ch !== 8'h00) begin fails++; $display("FAIL mid_reset_ch: got %h want 00", out_ch); end
        tests++; if (in_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_in_valid: got %b want 0", in_valid); end
        reset = 1'b0;
        bus(1'b1, 8'h00, A_ST, 64'h0);
        tick();
        bus_idle();
        tests++; if (rdata !== 64'h2) begin fails++; $display("FAIL mid_reset_status: got %h want 2", rdata); end
        snap = sent_cnt;
        drain(40);
        tests++; if (sent_cnt != snap) begin fails++; $display("FAIL mid_reset_no_tx: got %0d strobes want 0", sent_cnt - snap); end
        $display("[TB] reset_mid: STATUS=2, no further output");
    endtask

    task automatic test_decode();
        int snap = sent_cnt;
        bus(1'b1, 8'hFF, BASE + 64'h100, 64'h77); tick();
        bus(1'b1, 8'hFE, A_TX, 64'h66); tick();
        bus(1'b1, 8'hFF, BASE + 64'h18, 64'hFFFF); tick();
        bus(1'b0, 8'h01, A_TX, 64'h55); tick();
        bus(1'b1, 8'hFF, A_RX, 64'h33); tick();
        bus(1'b1, 8'h00, A_ST, 64'h0); tick();
        tests++; if (rdata !== 64'h2) begin fails++; $display("FAIL decode_status: got %h want 2", rdata); end
        bus(1'b1, 8'h00, BASE + 64'h108, 64'h0); tick();
        tests++; if (rdata !== 64'h2) begin fails++; $display("FAIL decode_other_window: got %h want 2", rdata); end
        bus(1'b1, 8'h00, BASE + 64'h18, 64'h0); tick();
        tests++; if (rdata !== 64'h0) begin fails++; $display("FAIL decode_off18: got %h want 0", rdata); end
        bus(1'b1, 8'h00, A_ST, 64'h0); tick();
        bus(1'b1, 8'h00, A_TX, 64'h0); tick();
        tests++; if (rdata !== 64'h0) begin fails++; $display("FAIL decode_txdata_read: got %h want 0", rdata); end
        drain(30);
        tests++; if (sent_cnt != snap) begin fails++; $display("FAIL decode_no_tx: got %0d strobes want 0", sent_cnt - snap); end
        $display("[TB] decode: stray accesses had no effect");
    endtask

    // Randomized traffic against a behavioural model: byte queue plus send schedule.
    task automatic test_random();
        logic [7:0]  q[$];
        int          n, send_at, next_check, popping, avail, size0, pcnt, r;
        logic [7:0]  send_byte, last_ch, rxd, moff;
        bit          ovf, rxv, msel, mwr, mrd, exp_v, exp_poll;
        logic [63:0] exp_rd, st;
        int          start_fails = fails;
        reset = 1'b1;
        bus_idle();
        in_ch = 8'hFF;
        tick(); tick();
        reset = 1'b0;
        q.delete();
        send_at = -1; next_check = 0; last_ch = 8'h00; ovf = 0; rxv = 0; rxd = 8'h00;
        pcnt = 0; exp_rd = 64'h0;
        for (n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 30) bus(1'b1, ($urandom_range(0, 9) == 0) ? 8'h02 : 8'hFF, A_TX, {$urandom, $urandom});
            else if (r < 40) bus(1'b1, 8'h00, A_ST, 64'h0);
            else if (r < 45) bus(1'b1, ($urandom_range(0, 3) == 0) ? 8'h02 : 8'h01, A_ST, {$urandom, $urandom});
            else if (r < 55) bus(1'b1, 8'h00, A_RX, 64'h0);
            else if (r < 58) bus(1'b1, 8'h00, BASE + 64'h18, 64'h0);
            else if (r < 60) bus(1'b0, 8'h01, A_TX, 64'h99);
            else if (r < 62) bus(1'b1, 8'h00, BASE + 64'h108, 64'h0);
            else bus_idle();
            in_ch = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);

            exp_v = (send_at == n);
            if (exp_v) last_ch = send_byte;
            exp_poll = !rxv && (pcnt == POLL - 1);
            tests++; if (out_valid !== exp_v) begin fails++; $display("FAIL rnd_valid n=%0d: got %b want %b", n, out_valid, exp_v); end
            tests++; if (out_ch !== last_ch) begin fails++; $display("FAIL rnd_ch n=%0d: got %h want %h", n, out_ch, last_ch); end
            tests++; if (in_valid !== exp_poll) begin fails++; $display("FAIL rnd_poll n=%0d: got %b want %b", n, in_valid, exp_poll); end
            tests++; if (rdata !== exp_rd) begin fails++; $display("FAIL rnd_rdata n=%0d: got %h want %h", n, rdata, exp_rd); end

            msel = en && (addr[63:8] == BASE[63:8]);
            moff = addr[7:0];
            mwr  = msel && (we != 8'h00);
            mrd  = msel && (we == 8'h00);
            size0 = q.size();
            st = {48'h0, 8'(size0), 4'h0, ovf, rxv, (size0 == 0), (size0 == DEPTH)};
            if (mrd) begin
                if (moff == 8'h08) exp_rd = st;
                else if (moff == 8'h10) exp_rd = rxv ? {56'h0, rxd} : 64'hFF;
                else exp_rd = 64'h0;
            end
            popping = (send_at == n) ? 1 : 0;
            avail = size0 - popping;
            if (n >= next_check && avail > 0 && send_at <= n) begin
                send_at = n + 1;
                send_byte = q[popping];
                next_check = n + 1 + GAP;
            end
            if (popping == 1) void'(q.pop_front());
            if (mwr && moff == 8'h00 && we[0]) begin
                if (size0 < DEPTH || popping == 1) q.push_back(wdata[7:0]);
                else ovf = 1;
            end else if (mwr && moff == 8'h08 && we[0] && wdata[3]) begin
                ovf = 0;
            end
            if (mrd && moff == 8'h10 && rxv) begin
                rxv = 0;
            end else if (!rxv) begin
                if (pcnt == POLL - 1) begin
                    pcnt = 0;
                    if (in_ch != 8'hFF) begin rxv = 1; rxd = in_ch; end
                end else begin
                    pcnt++;
                end
            end
            tick();
        end
        bus_idle();
        $display("[TB] random: %0d cycles, %0d mismatching checks", n, fails - start_fails);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_full_send_push();
        test_overflow();
        test_rx();
        test_reset_mid();
        test_decode();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
